sram_cmd_sequencer: RTL and testbench

SRAM_CMD_SEQUENCER -- requirements
Module: sram_cmd_sequencer

---
 rtl/sram_cmd_sequencer_pkg.sv | 25 ++
 rtl/sram_cmd_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_sram_cmd_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_cmd_sequencer_pkg.sv
// Shared constants for the SRAM command sequencer: bus widths, host
// protocol command/response bytes and the FSM state encodings.
package sram_cmd_sequencer_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h3F;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE   = 4'd0;
   localparam state_t ST_HDR    = 4'd1;
   localparam state_t ST_WDATA  = 4'd2;
   localparam state_t ST_MREQ   = 4'd3;
   localparam state_t ST_MWAIT  = 4'd4;
   localparam state_t ST_TX_HI  = 4'd5;
   localparam state_t ST_TX_LO  = 4'd6;
   localparam state_t ST_TX_ACK = 4'd7;
   localparam state_t ST_TX_ERR = 4'd8;

endpackage

// File: rtl/sram_cmd_sequencer.sv
// Byte-stream command sequencer: parses host W/R frames and turns them into
// single-word requests on the SRAM controller port, streaming read data and
// write acknowledgements back to the host.
module sram_cmd_sequencer
   import sram_cmd_sequencer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_req,
   output logic                mem_wren,
   input  logic                mem_ready
);

   state_t              state_q, state_d;
   logic [2:0]          byte_cnt_q, byte_cnt_d;
   logic                cmd_wr_q, cmd_wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W:0]     count_q, count_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic                rx_fire;
   logic                tx_fire;

   // Output decode straight from registered state; tx_data is a function of
   // state and the holding register so it cannot change while tx_valid waits.
   always_comb begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      if (!rst) begin
         rx_ready = (state_q == ST_IDLE) || (state_q == ST_HDR) || (state_q == ST_WDATA);
      end
      case (state_q)
         ST_TX_HI: begin
            tx_valid = 1'b1;
            tx_data  = hold_q[15:8];
         end
         ST_TX_LO: begin
            tx_valid = 1'b1;
            tx_data  = hold_q[7:0];
         end
         ST_TX_ACK: begin
            tx_valid = 1'b1;
            tx_data  = RSP_OK;
         end
         ST_TX_ERR: begin
            tx_valid = 1'b1;
            tx_data  = RSP_ERR;
         end
         default: begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
         end
      endcase
   end

   assign rx_fire     = rx_valid & rx_ready;
   assign tx_fire     = tx_valid & tx_ready;
   assign mem_req     = (state_q == ST_MREQ);
   assign mem_wren    = cmd_wr_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;

   // Next-state logic: frame parsing, memory handshake and response sequencing.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      cmd_wr_d   = cmd_wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      count_d    = count_q;
      hold_d     = hold_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_fire) begin
               byte_cnt_d = 3'd0;
               if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                  cmd_wr_d = (rx_data == CMD_WRITE);
                  state_d  = ST_HDR;
               end else begin
                  state_d = ST_TX_ERR;
               end
            end
         end
         ST_HDR: begin
            if (rx_fire) begin
               byte_cnt_d = byte_cnt_q + 3'd1;
               case (byte_cnt_q)
                  3'd0:    addr_d[17:16] = rx_data[1:0];
                  3'd1:    addr_d[15:8]  = rx_data;
                  3'd2:    addr_d[7:0]   = rx_data;
                  3'd3:    count_d       = {1'b0, rx_data, 8'h00};
                  default: count_d       = {1'b0, count_q[15:8], rx_data} + 17'd1;
               endcase
               if (byte_cnt_q == 3'd4) begin
                  byte_cnt_d = 3'd0;
                  state_d    = cmd_wr_q ? ST_WDATA : ST_MREQ;
               end
            end
         end
         ST_WDATA: begin
            if (rx_fire) begin
               if (byte_cnt_q == 3'd0) begin
                  wdata_d[15:8] = rx_data;
                  byte_cnt_d    = 3'd1;
               end else begin
                  wdata_d[7:0] = rx_data;
                  byte_cnt_d   = 3'd0;
                  state_d      = ST_MREQ;
               end
            end
         end
         ST_MREQ: begin
            state_d = ST_MWAIT;
         end
         ST_MWAIT: begin
            if (mem_ready) begin
               hold_d  = mem_rdata;
               addr_d  = addr_q + 18'd1;
               count_d = count_q - 17'd1;
               if (!cmd_wr_q) begin
                  state_d = ST_TX_HI;
               end else if (count_q == 17'd1) begin
                  state_d = ST_TX_ACK;
               end else begin
                  state_d = ST_WDATA;
               end
            end
         end
         ST_TX_HI: begin
            if (tx_fire) begin
               state_d = ST_TX_LO;
            end
         end
         ST_TX_LO: begin
            if (tx_fire) begin
               state_d = (count_q != 17'd0) ? ST_MREQ : ST_IDLE;
            end
         end
         ST_TX_ACK, ST_TX_ERR: begin
            if (tx_fire) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= 3'd0;
         cmd_wr_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         count_q    <= '0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         cmd_wr_q   <= cmd_wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         count_q    <= count_d;
         hold_q     <= hold_d;
      end
   end

endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// Directed testbench for sram_cmd_sequencer with a simple SRAM responder.
module tb_sram_cmd_sequencer;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_valid = 1'b0;
   logic         rx_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready = 1'b1;
   logic [17:0]  mem_address;
   logic [15:0]  mem_wdata;
   logic [15:0]  mem_rdata = 16'h0000;
   logic         mem_req;
   logic         mem_wren;
   logic         mem_ready = 1'b0;

   int vectors = 0;
   int errors  = 0;

   logic [15:0] sram [int];
   logic [7:0]  tx_log [$];
   logic [17:0] wr_addr_log [$];
   logic [15:0] wr_data_log [$];
   logic [7:0]  frame [$];
   int          req_count = 0;
   int          req_wide = 0;
   int          rd_req_count = 0;
   int          mem_lat = 1;
   int          lat_cnt = 0;
   logic [17:0] pend_addr = '0;
   logic        prev_req = 1'b0;

   sram_cmd_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_req     (mem_req),
      .mem_wren    (mem_wren),
      .mem_ready   (mem_ready)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // SRAM responder and bus monitor, evaluated on the falling edge so every
   // DUT output has settled; mem_ready is a one-cycle pulse mem_lat cycles
   // after the request.
   always @(negedge clk) begin
      if (mem_ready) begin
         mem_ready = 1'b0;
      end
      if (lat_cnt > 0) begin
         lat_cnt = lat_cnt - 1;
         if (lat_cnt == 0) begin
            mem_ready = 1'b1;
            mem_rdata = sram.exists(int'(pend_addr)) ? sram[int'(pend_addr)] : 16'h0000;
         end
      end
      if (mem_req && prev_req) begin
         req_wide = req_wide + 1;
      end
      if (mem_req && !prev_req) begin
         req_count = req_count + 1;
         pend_addr = mem_address;
         lat_cnt   = mem_lat;
         if (mem_wren) begin
            sram[int'(mem_address)] = mem_wdata;
            wr_addr_log.push_back(mem_address);
            wr_data_log.push_back(mem_wdata);
         end else begin
            rd_req_count = rd_req_count + 1;
         end
      end
      prev_req = mem_req;
      if (tx_valid && tx_ready) begin
         tx_log.push_back(tx_data);
      end
   end

   // Clear per-test logs
   task automatic clear_logs();
      tx_log.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
      req_count    = 0;
      req_wide     = 0;
      rd_req_count = 0;
   endtask

   // Send the bytes queued in frame back to back, one per accepted cycle
   task automatic send_frame();
      foreach (frame[i]) begin
         int  budget;
         bit  done;
         budget   = 0;
         done     = 1'b0;
         rx_data  = frame[i];
         rx_valid = 1'b1;
         while (!done && budget < 300) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            @(posedge clk);
            #1;
            budget++;
         end
         if (!done) begin
            vectors++;
            errors++;
            $display("[TB] FAIL rx_accept byte %0d: got no rx_ready, required accept within 300 cycles", i);
         end
      end
      rx_valid = 1'b0;
   endtask

   // Wait until n tx bytes have been handshaken, bounded by a cycle budget
   task automatic wait_tx(input int n, input string name);
      int budget;
      budget = 0;
      while (tx_log.size() < n && budget < 500) begin
         @(posedge clk);
         #1;
         budget++;
      end
      vectors++;
      if (tx_log.size() < n) begin
         errors++;
         $display("[TB] FAIL %s tx_count: got %0d, required %0d", name, tx_log.size(), n);
      end
   endtask

   // Reset values while rst is held, then IDLE with rx_ready on release
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors += 7;
      if (rx_ready !== 1'b0)      begin errors++; $display("[TB] FAIL rst rx_ready: got %b, required 0", rx_ready); end
      if (tx_valid !== 1'b0)      begin errors++; $display("[TB] FAIL rst tx_valid: got %b, required 0", tx_valid); end
      if (tx_data !== 8'h00)      begin errors++; $display("[TB] FAIL rst tx_data: got %h, required 00", tx_data); end
      if (mem_req !== 1'b0)       begin errors++; $display("[TB] FAIL rst mem_req: got %b, required 0", mem_req); end
      if (mem_wren !== 1'b0)      begin errors++; $display("[TB] FAIL rst mem_wren: got %b, required 0", mem_wren); end
      if (mem_address !== 18'h0)  begin errors++; $display("[TB] FAIL rst mem_address: got %h, required 0", mem_address); end
      if (mem_wdata !== 16'h0)    begin errors++; $display("[TB] FAIL rst mem_wdata: got %h, required 0", mem_wdata); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      vectors += 2;
      if (rx_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst rx_ready: got %b, required 1", rx_ready); end
      if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst tx_valid: got %b, required 0", tx_valid); end
      @(posedge clk);
      #1;
   endtask

   // Two-word write at 0x00010 followed by the 'K' trailer
   task automatic test_write();
      clear_logs();
      frame = '{8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_frame();
      wait_tx(1, "write");
      vectors += 7;
      if (wr_addr_log.size() !== 2)    begin errors++; $display("[TB] FAIL write count: got %0d, required 2", wr_addr_log.size()); end
      if (wr_addr_log[0] !== 18'h00010) begin errors++; $display("[TB] FAIL write addr0: got %h, required 00010", wr_addr_log[0]); end
      if (wr_data_log[0] !== 16'hAABB)  begin errors++; $display("[TB] FAIL write data0: got %h, required aabb", wr_data_log[0]); end
      if (wr_addr_log[1] !== 18'h00011) begin errors++; $display("[TB] FAIL write addr1: got %h, required 00011", wr_addr_log[1]); end
      if (wr_data_log[1] !== 16'hCCDD)  begin errors++; $display("[TB] FAIL write data1: got %h, required ccdd", wr_data_log[1]); end
      if (tx_log[0] !== 8'h4B)          begin errors++; $display("[TB] FAIL write trailer: got %h, required 4b", tx_log[0]); end
      if (req_wide !== 0)               begin errors++; $display("[TB] FAIL write req_width: got %0d wide cycles, required 0", req_wide); end
   endtask

   // Two-word read of the data just written
   task automatic test_read();
      logic [7:0] exp [4];
      exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      clear_logs();
      frame = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01};
      send_frame();
      wait_tx(4, "read");
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (tx_log[i] !== exp[i]) begin errors++; $display("[TB] FAIL read byte%0d: got %h, required %h", i, tx_log[i], exp[i]); end
      end
      vectors += 4;
      if (tx_log.size() !== 4)  begin errors++; $display("[TB] FAIL read tx_total: got %0d, required 4", tx_log.size()); end
      if (req_count !== 2)      begin errors++; $display("[TB] FAIL read req_count: got %0d, required 2", req_count); end
      if (rd_req_count !== 2)   begin errors++; $display("[TB] FAIL read rd_req: got %0d, required 2", rd_req_count); end
      if (req_wide !== 0)       begin errors++; $display("[TB] FAIL read req_width: got %0d wide cycles, required 0", req_wide); end
   endtask

   // Address wrap 0x3FFFF -> 0x00000, with A2 upper bits set and ignored
   task automatic test_wrap();
      clear_logs();
      frame = '{8'h57, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      send_frame();
      wait_tx(1, "wrap");
      vectors += 5;
      if (wr_addr_log[0] !== 18'h3FFFF) begin errors++; $display("[TB] FAIL wrap addr0: got %h, required 3ffff", wr_addr_log[0]); end
      if (wr_data_log[0] !== 16'h1122)  begin errors++; $display("[TB] FAIL wrap data0: got %h, required 1122", wr_data_log[0]); end
      if (wr_addr_log[1] !== 18'h00000) begin errors++; $display("[TB] FAIL wrap addr1: got %h, required 00000", wr_addr_log[1]); end
      if (wr_data_log[1] !== 16'h3344)  begin errors++; $display("[TB] FAIL wrap data1: got %h, required 3344", wr_data_log[1]); end
      if (tx_log[0] !== 8'h4B)          begin errors++; $display("[TB] FAIL wrap trailer: got %h, required 4b", tx_log[0]); end
   endtask

   // Unknown command answered with '?', then a one-word read still works
   task automatic test_bad_cmd();
      clear_logs();
      frame = '{8'h13};
      send_frame();
      wait_tx(1, "bad_cmd");
      vectors++;
      if (tx_log[0] !== 8'h3F) begin errors++; $display("[TB] FAIL bad_cmd rsp: got %h, required 3f", tx_log[0]); end
      frame = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
      send_frame();
      wait_tx(3, "bad_cmd_read");
      vectors += 3;
      if (tx_log[1] !== 8'hAA) begin errors++; $display("[TB] FAIL bad_cmd read_hi: got %h, required aa", tx_log[1]); end
      if (tx_log[2] !== 8'hBB) begin errors++; $display("[TB] FAIL bad_cmd read_lo: got %h, required bb", tx_log[2]); end
      if (req_count !== 1)     begin errors++; $display("[TB] FAIL bad_cmd req_count: got %0d, required 1", req_count); end
   endtask

   // Host stalls for 20 cycles: first read byte held, no new request issued
   task automatic test_backpressure();
      int budget;
      int bad;
      logic [7:0] exp [4];
      exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      clear_logs();
      tx_ready = 1'b0;
      frame = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00, 8'h01};
      send_frame();
      budget = 0;
      while (!tx_valid && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (tx_valid !== 1'b1 || tx_data !== 8'hAA || req_count !== 1 || mem_req !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         errors++;
         $display("[TB] FAIL stall hold: got %0d unstable cycles (tx_valid=%b tx_data=%h reqs=%0d), required 0", bad, tx_valid, tx_data, req_count);
      end
      @(posedge clk);
      #1;
      tx_ready = 1'b1;
      wait_tx(4, "stall");
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (tx_log[i] !== exp[i]) begin errors++; $display("[TB] FAIL stall byte%0d: got %h, required %h", i, tx_log[i], exp[i]); end
      end
      vectors++;
      if (req_count !== 2) begin errors++; $display("[TB] FAIL stall req_count: got %0d, required 2", req_count); end
   endtask

   // Reset while a write waits on the controller; the late completion is ignored
   task automatic test_reset_mwait();
      clear_logs();
      mem_lat = 6;
      frame = '{8'h57, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h12, 8'h34};
      send_frame();
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_mwait req: got %b, required 1", mem_req); end
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      vectors += 6;
      if (mem_wren !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mwait wren: got %b, required 0", mem_wren); end
      if (mem_address !== 18'h0) begin errors++; $display("[TB] FAIL rst_mwait addr: got %h, required 0", mem_address); end
      if (mem_wdata !== 16'h0)   begin errors++; $display("[TB] FAIL rst_mwait wdata: got %h, required 0", mem_wdata); end
      if (mem_req !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mwait mem_req: got %b, required 0", mem_req); end
      if (rx_ready !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mwait rx_ready: got %b, required 0", rx_ready); end
      if (tx_valid !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mwait tx_valid: got %b, required 0", tx_valid); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      vectors += 3;
      if (rx_ready !== 1'b1)    begin errors++; $display("[TB] FAIL rst_mwait idle rx_ready: got %b, required 1", rx_ready); end
      if (tx_valid !== 1'b0)    begin errors++; $display("[TB] FAIL rst_mwait idle tx_valid: got %b, required 0", tx_valid); end
      if (tx_log.size() !== 0)  begin errors++; $display("[TB] FAIL rst_mwait stray_tx: got %0d bytes, required 0", tx_log.size()); end
      @(posedge clk);
      #1;
      mem_lat = 1;
      frame = '{8'h52, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
      send_frame();
      wait_tx(2, "rst_mwait_read");
      vectors += 2;
      if (tx_log[0] !== 8'hAA) begin errors++; $display("[TB] FAIL rst_mwait read_hi: got %h, required aa", tx_log[0]); end
      if (tx_log[1] !== 8'hBB) begin errors++; $display("[TB] FAIL rst_mwait read_lo: got %h, required bb", tx_log[1]); end
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_bad_cmd();
      test_backpressure();
      test_reset_mwait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
